gbc_upscaler: RTL and testbench



---
 rtl/gbc_video_pkg.sv | 44 ++++
 rtl/gbc_scale_counter.sv | 56 +++++
 rtl/gbc_upscaler.sv | 154 +++++++++++++++
 tb/tb_gbc_upscaler.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/gbc_video_pkg.sv
// Shared constants and helpers for the GBC-to-720p video path:
// frame-buffer geometry, VRAM address width, RGB332 field layout and
// the 1280x720 raster dimensions.
package gbc_video_pkg;

    localparam int GBC_H_PIXELS    = 160;
    localparam int GBC_V_PIXELS    = 144;
    localparam int VRAM_ADDR_WIDTH = 15;

    localparam int RASTER_H_ACTIVE = 1280;
    localparam int RASTER_V_ACTIVE = 720;

    // RGB332 byte layout
    localparam int RGB_R_MSB = 7;
    localparam int RGB_R_LSB = 5;
    localparam int RGB_G_MSB = 4;
    localparam int RGB_G_LSB = 2;
    localparam int RGB_B_MSB = 1;
    localparam int RGB_B_LSB = 0;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    function automatic rgb332_t rgb332_unpack(input logic [7:0] d);
        rgb332_t p;
        p.r = d[RGB_R_MSB:RGB_R_LSB];
        p.g = d[RGB_G_MSB:RGB_G_LSB];
        p.b = d[RGB_B_MSB:RGB_B_LSB];
        return p;
    endfunction

    // Halve each channel; used for the dimmed scanline row.
    function automatic rgb332_t rgb332_dim(input rgb332_t p);
        rgb332_t q;
        q.r = p.r >> 1;
        q.g = p.g >> 1;
        q.b = p.b >> 1;
        return q;
    endfunction

endpackage

// File: rtl/gbc_scale_counter.sv
// Replication counter: a sub-count 0..SCALE-1 and an index that advances
// by IDX_STEP each time the sub-count wraps, saturating at IDX_MAX.
// The sub/idx outputs are the values in effect for the current pixel:
// a clear applies to this pixel, and a step on the same pixel advances
// from the cleared value.
module gbc_scale_counter #(
    parameter  int SCALE    = 5,
    parameter  int IDX_W    = 8,
    parameter  int IDX_STEP = 1,
    parameter  int IDX_MAX  = 159,
    localparam int SUB_W    = (SCALE > 1) ? $clog2(SCALE) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             stp,
    output logic [SUB_W-1:0] sub,
    output logic [IDX_W-1:0] idx
);

    logic [SUB_W-1:0] sub_q, sub_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Effective value for the current pixel: clear takes effect immediately
    always_comb begin
        sub = clr ? '0 : sub_q;
        idx = clr ? '0 : idx_q;
    end

    // Next state: step from the effective value, wrap sub, saturate idx
    always_comb begin
        sub_d = sub;
        idx_d = idx;
        if (stp) begin
            if (sub == SUB_W'(SCALE - 1)) begin
                sub_d = '0;
                if (idx < IDX_W'(IDX_MAX))
                    idx_d = idx + IDX_W'(IDX_STEP);
            end else begin
                sub_d = sub + 1'b1;
            end
        end
    end

    // Counter state register
    always_ff @(posedge clk) begin
        if (rst) begin
            sub_q <= '0;
            idx_q <= '0;
        end else begin
            sub_q <= sub_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/gbc_upscaler.sv
// Maps the 1280x720 raster onto the 160x144 GBC frame buffer with integer
// replication, centred by X_OFFSET/Y_OFFSET, black outside the window.
// VRAM addresses come from two replication counters (no multiplier).
// Syncs are delayed 2+VRAM_LATENCY clocks so they leave aligned with RGB.
// Optional: define GBC_SCANLINE_EN to dim the last replicated line of each
// source row (each channel shifted right by one). VRAM_LATENCY must be >= 1.
module gbc_upscaler
    import gbc_video_pkg::*;
#(
    parameter int SCALE        = 5,
    parameter int X_OFFSET     = 240,
    parameter int Y_OFFSET     = 0,
    parameter int VRAM_LATENCY = 1
) (
    input  logic                       i_clkPixel,
    input  logic                       i_reset,
    input  logic                       i_hSync,
    input  logic                       i_vSync,
    input  logic                       i_active,
    input  logic [15:0]                i_x,
    input  logic [15:0]                i_y,
    input  logic [7:0]                 i_vramData,
    output logic [VRAM_ADDR_WIDTH-1:0] o_vramReadAddr,
    output logic                       o_hSync,
    output logic                       o_vSync,
    output logic [2:0]                 o_red,
    output logic [2:0]                 o_green,
    output logic [1:0]                 o_blue
);

    localparam int WIN_W      = GBC_H_PIXELS * SCALE;
    localparam int WIN_H      = GBC_V_PIXELS * SCALE;
    localparam int VLD_STAGES = 1 + VRAM_LATENCY;
    localparam int SYNC_DLY   = 2 + VRAM_LATENCY;
    localparam int SUB_W      = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int COL_W      = $clog2(GBC_H_PIXELS);

    logic [16:0]                dx, dy;
    logic                       in_x, in_y, in_win;
    logic                       x_start, frame_start, y_clr, line_end;
    logic [SUB_W-1:0]           sub_x, sub_y;
    logic [COL_W-1:0]           col;
    logic [VRAM_ADDR_WIDTH-1:0] row_base;
    logic [VLD_STAGES-1:0]      vld_pipe;
    logic [SYNC_DLY-1:0]        hs_pipe, vs_pipe;
    rgb332_t                    pix, pix_out;

    // Window test via offset subtraction; bit 16 is the borrow (before window)
    always_comb begin
        dx          = {1'b0, i_x} - 17'(X_OFFSET);
        dy          = {1'b0, i_y} - 17'(Y_OFFSET);
        in_x        = ~dx[16] & (dx[15:0] < 16'(WIN_W));
        in_y        = ~dy[16] & (dy[15:0] < 16'(WIN_H));
        in_win      = i_active & in_x & in_y;
        x_start     = (i_x == 16'(X_OFFSET));
        frame_start = i_active & (i_x == '0) & (i_y == '0);
        y_clr       = frame_start | dy[16];
        line_end    = in_win & (i_x == 16'(X_OFFSET + WIN_W - 1));
    end

    gbc_scale_counter #(
        .SCALE    (SCALE),
        .IDX_W    (COL_W),
        .IDX_STEP (1),
        .IDX_MAX  (GBC_H_PIXELS - 1)
    ) u_x_cnt (
        .clk (i_clkPixel),
        .rst (i_reset),
        .clr (x_start),
        .stp (in_win),
        .sub (sub_x),
        .idx (col)
    );

    // Frame-start clear wins over a coincident end-of-line step
    gbc_scale_counter #(
        .SCALE    (SCALE),
        .IDX_W    (VRAM_ADDR_WIDTH),
        .IDX_STEP (GBC_H_PIXELS),
        .IDX_MAX  ((GBC_V_PIXELS - 1) * GBC_H_PIXELS)
    ) u_y_cnt (
        .clk (i_clkPixel),
        .rst (i_reset),
        .clr (y_clr),
        .stp (line_end & ~y_clr),
        .sub (sub_y),
        .idx (row_base)
    );

    // VRAM read address; holds its last value outside the window
    always_ff @(posedge i_clkPixel) begin
        if (i_reset)
            o_vramReadAddr <= '0;
        else if (in_win)
            o_vramReadAddr <= row_base + VRAM_ADDR_WIDTH'(col);
    end

    // Window flag follows the address through the VRAM read latency
    always_ff @(posedge i_clkPixel) begin
        if (i_reset)
            vld_pipe <= '0;
        else
            vld_pipe <= {vld_pipe[VLD_STAGES-2:0], in_win};
    end

    // Sync delay lines, polarity untouched
    always_ff @(posedge i_clkPixel) begin
        if (i_reset) begin
            hs_pipe <= '0;
            vs_pipe <= '0;
        end else begin
            hs_pipe <= {hs_pipe[SYNC_DLY-2:0], i_hSync};
            vs_pipe <= {vs_pipe[SYNC_DLY-2:0], i_vSync};
        end
    end

    assign o_hSync = hs_pipe[SYNC_DLY-1];
    assign o_vSync = vs_pipe[SYNC_DLY-1];
    assign pix     = rgb332_unpack(i_vramData);

`ifdef GBC_SCANLINE_EN
    logic [VLD_STAGES-1:0] scan_pipe;
    logic                  unused_sub;
    assign unused_sub = ^sub_x;

    // Last-sub-row flag travels with the window flag
    always_ff @(posedge i_clkPixel) begin
        if (i_reset)
            scan_pipe <= '0;
        else
            scan_pipe <= {scan_pipe[VLD_STAGES-2:0], (sub_y == SUB_W'(SCALE - 1))};
    end

    assign pix_out = scan_pipe[VLD_STAGES-1] ? rgb332_dim(pix) : pix;
`else
    logic unused_sub;
    assign unused_sub = ^{sub_x, sub_y};
    assign pix_out    = pix;
`endif

    // RGB output register: VRAM pixel inside the window, black outside
    always_ff @(posedge i_clkPixel) begin
        if (i_reset || !vld_pipe[VLD_STAGES-1]) begin
            o_red   <= '0;
            o_green <= '0;
            o_blue  <= '0;
        end else begin
            o_red   <= pix_out.r;
            o_green <= pix_out.g;
            o_blue  <= pix_out.b;
        end
    end

endmodule

// File: tb/tb_gbc_upscaler.sv
// Directed bench for gbc_upscaler: drives a (partly compressed) 720p raster,
// checks address checkpoints from a table, and checks RGB/sync alignment
// three clocks after each pixel. Honors GBC_SCANLINE_EN if defined.
module tb_gbc_upscaler;

    logic        clk = 1'b0;
    logic        rst;
    logic        hs, vs, act;
    logic [15:0] x, y;
    logic [7:0]  vram_data;
    logic [14:0] addr;
    logic        o_hs, o_vs;
    logic [2:0]  red, green;
    logic [1:0]  blue;
    logic        pat_mode;

    always #5 clk = ~clk;

    gbc_upscaler dut (
        .i_clkPixel     (clk),
        .i_reset        (rst),
        .i_hSync        (hs),
        .i_vSync        (vs),
        .i_active       (act),
        .i_x            (x),
        .i_y            (y),
        .i_vramData     (vram_data),
        .o_vramReadAddr (addr),
        .o_hSync        (o_hs),
        .o_vSync        (o_vs),
        .o_red          (red),
        .o_green        (green),
        .o_blue         (blue)
    );

    // One-clock VRAM: constant 8'hE5, or the low address byte in pattern mode
    always_ff @(posedge clk) vram_data <= pat_mode ? addr[7:0] : 8'hE5;

    typedef struct {
        logic [7:0] rgb;
        logic       hs;
        logic       vs;
    } exp_t;

    typedef struct {
        int ph;
        int y;
        int x;
        int ea;
    } vec_t;

    vec_t        tbl[14];
    exp_t        pend0, pend1;
    logic [14:0] exp_addr;
    bit          addr_known;
    int          phase;
    int          n_chk = 0;
    int          n_pass = 0;

    function automatic logic [7:0] exp_rgb(input logic [7:0] d, input int yy);
        logic [7:0] r;
        r = d;
`ifdef GBC_SCANLINE_EN
        if (yy % 5 == 4) r = {1'b0, d[7:6], 1'b0, d[4:3], 1'b0, d[1]};
`endif
        return r;
    endfunction

    task automatic check(input string nm, input int actual, input int req, input int px, input int py);
        n_chk++;
        if (actual == req) n_pass++;
        else $display("FAIL %s x=%0d y=%0d actual=%0h required=%0h", nm, px, py, actual, req);
    endtask

    // Apply one pixel; full=1 means the line is driven contiguously so the
    // address is predictable from (x,y).
    task automatic step(input int px, input int py, input bit a, input bit r, input bit full);
        logic       h, v, win;
        logic [7:0] d;
        exp_t       cur;
        h   = (px >= 1285 && px < 1290);
        v   = (py >= 725 && py < 730);
        win = a && px >= 240 && px < 1040 && py < 720;
        x = 16'(px); y = 16'(py); act = a; hs = h; vs = v; rst = r;
        @(posedge clk);
        #1;
        if (r) begin
            check("rst_addr", int'(addr), 0, px, py);
            check("rst_rgb", int'({red, green, blue}), 0, px, py);
            check("rst_sync", int'({o_hs, o_vs}), 0, px, py);
            pend0 = '{8'h00, 1'b0, 1'b0};
            pend1 = '{8'h00, 1'b0, 1'b0};
            exp_addr = '0;
            addr_known = 1'b1;
        end else begin
            if (win) begin
                exp_addr   = 15'((py / 5) * 160 + (px - 240) / 5);
                addr_known = full;
            end
            if (full && addr_known) check("addr", int'(addr), int'(exp_addr), px, py);
            d = pat_mode ? exp_addr[7:0] : 8'hE5;
            cur.rgb = win ? exp_rgb(d, py) : 8'h00;
            cur.hs  = h;
            cur.vs  = v;
            check("rgb", int'({red, green, blue}), int'(pend1.rgb), px, py);
            check("hsync", int'(o_hs), int'(pend1.hs), px, py);
            check("vsync", int'(o_vs), int'(pend1.vs), px, py);
            pend1 = pend0;
            pend0 = cur;
            for (int i = 0; i < 14; i++)
                if (tbl[i].ph == phase && tbl[i].y == py && tbl[i].x == px)
                    check("tbl_addr", int'(addr), tbl[i].ea, px, py);
        end
    endtask

    task automatic full_line(input int py);
        for (int i = 0; i < 1300; i++) step(i, py, i < 1280, 1'b0, 1'b1);
    endtask

    // Compressed line: enough pixels for frame start, window edges and hsync
    task automatic short_line(input int py);
        step(0, py, 1'b1, 1'b0, 1'b0);
        step(240, py, 1'b1, 1'b0, 1'b0);
        step(1039, py, 1'b1, 1'b0, 1'b0);
        step(1285, py, 1'b0, 1'b0, 1'b0);
        step(1295, py, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        tbl[0]  = '{0, 0, 240, 0};
        tbl[1]  = '{0, 0, 244, 0};
        tbl[2]  = '{0, 0, 245, 1};
        tbl[3]  = '{0, 0, 1039, 159};
        tbl[4]  = '{0, 0, 1040, 159};
        tbl[5]  = '{0, 1, 240, 0};
        tbl[6]  = '{0, 3, 600, 72};
        tbl[7]  = '{0, 4, 1039, 159};
        tbl[8]  = '{0, 5, 240, 160};
        tbl[9]  = '{0, 5, 1039, 319};
        tbl[10] = '{0, 719, 1039, 23039};
        tbl[11] = '{1, 300, 599, 9671};
        tbl[12] = '{2, 0, 240, 0};
        tbl[13] = '{2, 0, 1039, 159};

        pend0 = '{8'h00, 1'b0, 1'b0};
        pend1 = '{8'h00, 1'b0, 1'b0};
        exp_addr = '0;
        addr_known = 1'b1;
        pat_mode = 1'b1;
        phase = 0;
        rst = 1'b1; hs = 1'b0; vs = 1'b0; act = 1'b0; x = '0; y = '0;

        // Reset held 10 clocks with the raster running through the window
        for (int i = 0; i < 10; i++) step(236 + i, 0, 1'b1, 1'b1, 1'b0);

        // Frame 1: address pattern on lines 0-5, constant colour afterwards
        for (int l = 0; l < 6; l++) full_line(l);
        pat_mode = 1'b0;
        for (int l = 6; l < 719; l++) short_line(l);
        full_line(719);
        for (int l = 720; l < 730; l++) begin
            step(0, l, 1'b1, 1'b0, 1'b0);
            step(500, l, 1'b1, 1'b0, 1'b0);
            step(1039, l, 1'b1, 1'b0, 1'b0);
        end

        // Frame 2: reset pulse mid-line at line 300, x=600
        phase = 1;
        for (int l = 0; l < 300; l++) short_line(l);
        for (int i = 0; i < 600; i++) step(i, 300, 1'b1, 1'b0, 1'b1);
        step(600, 300, 1'b1, 1'b1, 1'b0);
        for (int i = 601; i < 1300; i++) step(i, 300, i < 1280, 1'b0, 1'b0);

        // Frame 3: clean recovery
        phase = 2;
        full_line(0);
        short_line(1);
        for (int i = 0; i < 4; i++) step(1295, 1, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
